// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
// Module : acc_bank
// Column-parallel accumulator bank for skewed partial sums. Each column keeps
// DEPTH entries and runs COLS-1 skew stages behind column 0.
// Rev    : 1.0
// ============================================================================
module acc_bank #(
    parameter int COLS   = 4,
    parameter int P_BW   = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int SAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_start,
    input  logic                          in_last,
    input  logic [COLS-1:0][P_BW-1:0]     in_data,
    output logic [COLS-1:0]               out_valid,
    output logic [COLS-1:0][ACC_BW-1:0]   out_data,
    output logic [COLS-1:0]               overflow,
    output logic                          done
);

    localparam int                c_rw       = $clog2(DEPTH);
    localparam logic [c_rw-1:0]   c_last_row = c_rw'(DEPTH - 1);
    localparam logic [ACC_BW-1:0] c_acc_max  = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] c_acc_min  = {1'b1, {(ACC_BW-1){1'b0}}};

    logic [c_rw-1:0] r_row;
    logic            r_start;
    logic            r_last;
    logic            r_done;
    logic            w_first;

    // Per-column view of the beat that column acts on in the current cycle
    logic [COLS-1:0]           w_act;
    logic [COLS-1:0]           w_ast;
    logic [COLS-1:0]           w_als;
    logic [COLS-1:0][c_rw-1:0] w_arow;

    assign w_first = (r_row == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
        end else if (in_valid) begin
            if (w_first) begin
                r_start <= in_start;
                r_last  <= in_last;
            end
            r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic signed [ACC_BW-1:0] r_mem [DEPTH];
        logic signed [ACC_BW-1:0] w_ext;
        logic signed [ACC_BW-1:0] w_cur;
        logic signed [ACC_BW-1:0] w_new;
        logic        [ACC_BW:0]   w_sum;
        logic                     w_ovf;
        logic                     r_oval;
        logic        [ACC_BW-1:0] r_odat;
        logic                     r_ovf;

        if (c == 0) begin : g_head
            // Row 0 uses the live flags; later rows use the latched ones
            assign w_act[0]  = in_valid;
            assign w_ast[0]  = w_first ? in_start : r_start;
            assign w_als[0]  = w_first ? in_last  : r_last;
            assign w_arow[0] = r_row;
        end else begin : g_skew
            logic            r_act;
            logic            r_st;
            logic            r_ls;
            logic [c_rw-1:0] r_arow;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_act  <= 1'b0;
                    r_st   <= 1'b0;
                    r_ls   <= 1'b0;
                    r_arow <= '0;
                end else begin
                    r_act  <= w_act[c-1];
                    r_st   <= w_ast[c-1];
                    r_ls   <= w_als[c-1];
                    r_arow <= w_arow[c-1];
                end
            end

            assign w_act[c]  = r_act;
            assign w_ast[c]  = r_st;
            assign w_als[c]  = r_ls;
            assign w_arow[c] = r_arow;
        end

        if (ACC_BW > P_BW) begin : g_sext
            assign w_ext = {{(ACC_BW-P_BW){in_data[c][P_BW-1]}}, in_data[c]};
        end else begin : g_noext
            assign w_ext = in_data[c];
        end

        assign w_cur = r_mem[w_arow[c]];
        // One guard bit: overflow iff the two top bits of the sum disagree
        assign w_sum = {w_cur[ACC_BW-1], w_cur} + {w_ext[ACC_BW-1], w_ext};
        assign w_ovf = w_sum[ACC_BW] ^ w_sum[ACC_BW-1];

        always_comb begin
            w_new = w_sum[ACC_BW-1:0];
            if (w_ast[c]) begin
                w_new = w_ext;
            end else if (w_ovf && (SAT != 0)) begin
                w_new = w_sum[ACC_BW] ? c_acc_min : c_acc_max;
            end
        end

        always_ff @(posedge clk) begin
            if (w_act[c] && !rst) begin
                r_mem[w_arow[c]] <= w_new;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_oval <= 1'b0;
                r_odat <= '0;
                r_ovf  <= 1'b0;
            end else begin
                r_oval <= w_act[c] & w_als[c];
                if (w_act[c] && w_als[c]) begin
                    r_odat <= w_new;
                end
                if (w_act[c]) begin
                    r_ovf <= w_ast[c] ? 1'b0 : (r_ovf | w_ovf);
                end
            end
        end

        assign out_valid[c] = r_oval;
        assign out_data[c]  = r_odat;
        assign overflow[c]  = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_act[COLS-1] & w_als[COLS-1] & (w_arow[COLS-1] == c_last_row);
        end
    end

    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_acc_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_acc_bank
// Directed bench for acc_bank: a wide DEPTH=2 instance plus two 8-bit
// instances (saturating and wrapping). Rev 1.0
// ============================================================================
module tb_acc_bank;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_start;
    logic in_last;
    logic [3:0][15:0] in_data;
    logic [1:0][7:0]  s_in_data;

    logic [3:0]       out_valid;
    logic [3:0][31:0] out_data;
    logic [3:0]       overflow;
    logic             done;

    logic [1:0]       sv_out_valid, wv_out_valid;
    logic [1:0][7:0]  sv_out_data,  wv_out_data;
    logic [1:0]       sv_overflow,  wv_overflow;
    logic             sv_done,      wv_done;

    assign s_in_data = {in_data[1][7:0], in_data[0][7:0]};

    acc_bank #(.COLS(4), .P_BW(16), .ACC_BW(32), .DEPTH(2), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
        .in_last(in_last), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .overflow(overflow), .done(done));

    acc_bank #(.COLS(2), .P_BW(8), .ACC_BW(8), .DEPTH(2), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
        .in_last(in_last), .in_data(s_in_data), .out_valid(sv_out_valid),
        .out_data(sv_out_data), .overflow(sv_overflow), .done(sv_done));

    acc_bank #(.COLS(2), .P_BW(8), .ACC_BW(8), .DEPTH(2), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
        .in_last(in_last), .in_data(s_in_data), .out_valid(wv_out_valid),
        .out_data(wv_out_data), .overflow(wv_overflow), .done(wv_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Column-0 schedule; column c data is applied c cycles later by run_sched
    logic sched_v [64];
    logic sched_s [64];
    logic sched_l [64];
    logic sched_r [64];
    int   sched_d [64][4];

    logic [3:0]       cap_v    [64];
    logic [3:0][31:0] cap_d    [64];
    logic             cap_done [64];
    logic [3:0]       cap_ovf  [64];
    logic [1:0]       sv_v [64], wv_v [64];
    logic [1:0][7:0]  sv_d [64], wv_d [64];
    logic [1:0]       sv_o [64], wv_o [64];
    logic             sv_dn [64];

    task automatic clr_sched();
        for (int t = 0; t < 64; t++) begin
            sched_v[t] = 1'b0; sched_s[t] = 1'b0; sched_l[t] = 1'b0; sched_r[t] = 1'b0;
            for (int c = 0; c < 4; c++) sched_d[t][c] = 0;
        end
    endtask

    task automatic beat(input int t, input logic s, input logic l, input int d);
        sched_v[t] = 1'b1; sched_s[t] = s; sched_l[t] = l;
        for (int c = 0; c < 4; c++) sched_d[t][c] = d;
    endtask

    task automatic capture(input int k);
        cap_v[k] = out_valid; cap_d[k] = out_data; cap_done[k] = done; cap_ovf[k] = overflow;
        sv_v[k] = sv_out_valid; sv_d[k] = sv_out_data; sv_o[k] = sv_overflow; sv_dn[k] = sv_done;
        wv_v[k] = wv_out_valid; wv_d[k] = wv_out_data; wv_o[k] = wv_overflow;
    endtask

    // Drives n scheduled cycles plus extra idle ones; cap[k] holds the outputs seen in cycle k
    task automatic run_sched(input int n, input int extra);
        int idx;
        int tmp;
        capture(0);
        for (int t = 0; t < n + extra; t++) begin
            in_valid = (t < n) ? sched_v[t] : 1'b0;
            in_start = (t < n) ? sched_s[t] : 1'b0;
            in_last  = (t < n) ? sched_l[t] : 1'b0;
            rst      = (t < n) ? sched_r[t] : 1'b0;
            for (int c = 0; c < 4; c++) begin
                idx = t - c;
                if (idx >= 0 && idx < n && sched_v[idx]) begin
                    tmp = sched_d[idx][c];
                    in_data[c] = tmp[15:0];
                end else begin
                    in_data[c] = 16'h7777;
                end
            end
            @(posedge clk);
            #1;
            capture(t + 1);
        end
        in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; rst = 1'b0;
        in_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 4'b0 || done !== 1'b0 || overflow !== 4'b0)
            $display("FAIL reset_ctl got v=%b d=%b o=%b exp 0", out_valid, done, overflow);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_data got %h exp 0", out_data);
        else n_pass++;
        n_checks++;
        if (sv_out_valid !== 2'b0 || sv_out_data !== '0 || sv_overflow !== 2'b0 || sv_done !== 1'b0)
            $display("FAIL reset_sat got v=%b d=%h o=%b exp 0", sv_out_valid, sv_out_data, sv_overflow);
        else n_pass++;
        n_checks++;
        if (wv_out_valid !== 2'b0 || wv_out_data !== '0 || wv_overflow !== 2'b0 || wv_done !== 1'b0)
            $display("FAIL reset_wrap got v=%b d=%h o=%b exp 0", wv_out_valid, wv_out_data, wv_overflow);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        logic ev;
        int   ed;
        clr_sched();
        beat(0, 1'b1, 1'b1, 5);
        beat(1, 1'b0, 1'b0, -3);
        run_sched(2, 8);
        for (int k = 0; k <= 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                ev = (k == c + 1) || (k == c + 2);
                ed = (k == c + 1) ? 5 : -3;
                n_checks++;
                if (cap_v[k][c] !== ev) $display("FAIL single_valid k=%0d c=%0d got %b exp %b", k, c, cap_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (cap_d[k][c] !== 32'(ed)) $display("FAIL single_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(cap_d[k][c]), ed);
                    else n_pass++;
                end
            end
            n_checks++;
            if (cap_done[k] !== (k == 5)) $display("FAIL single_done k=%0d got %b exp %b", k, cap_done[k], (k == 5));
            else n_pass++;
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (cap_d[10][c] !== 32'hFFFF_FFFD) $display("FAIL single_hold c=%0d got %h exp fffffffd", c, cap_d[10][c]);
            else n_pass++;
        end
    endtask

    task automatic test_multi_pass();
        logic ev;
        clr_sched();
        beat(0, 1'b1, 1'b0, 1);
        beat(1, 1'b0, 1'b0, 1);
        beat(2, 1'b0, 1'b0, 1);
        beat(3, 1'b1, 1'b1, 1);   // flags on row 1 must be ignored
        beat(4, 1'b0, 1'b1, 1);
        beat(5, 1'b0, 1'b0, 1);
        run_sched(6, 7);
        for (int k = 0; k <= 13; k++) begin
            for (int c = 0; c < 4; c++) begin
                ev = (k == c + 5) || (k == c + 6);
                n_checks++;
                if (cap_v[k][c] !== ev) $display("FAIL multi_valid k=%0d c=%0d got %b exp %b", k, c, cap_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (cap_d[k][c] !== 32'd3) $display("FAIL multi_data k=%0d c=%0d got %0d exp 3", k, c, $signed(cap_d[k][c]));
                    else n_pass++;
                end
            end
            n_checks++;
            if (cap_done[k] !== (k == 9)) $display("FAIL multi_done k=%0d got %b exp %b", k, cap_done[k], (k == 9));
            else n_pass++;
        end
        n_checks++;
        if (cap_ovf[13] !== 4'b0) $display("FAIL multi_ovf got %b exp 0000", cap_ovf[13]);
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic ev;
        int   ed;
        clr_sched();
        beat(0, 1'b1, 1'b1, 5);
        for (int t = 1; t <= 3; t++) begin
            sched_s[t] = 1'b1; sched_l[t] = 1'b1;
        end
        beat(4, 1'b0, 1'b0, -3);
        run_sched(5, 7);
        for (int k = 0; k <= 12; k++) begin
            for (int c = 0; c < 4; c++) begin
                ev = (k == c + 1) || (k == c + 5);
                ed = (k == c + 1) ? 5 : -3;
                n_checks++;
                if (cap_v[k][c] !== ev) $display("FAIL gap_valid k=%0d c=%0d got %b exp %b", k, c, cap_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (cap_d[k][c] !== 32'(ed)) $display("FAIL gap_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(cap_d[k][c]), ed);
                    else n_pass++;
                end
            end
            n_checks++;
            if (cap_done[k] !== (k == 8)) $display("FAIL gap_done k=%0d got %b exp %b", k, cap_done[k], (k == 8));
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic ev;
        int   ed, es, ew;
        clr_sched();
        beat(0, 1'b1, 1'b0, 100);
        beat(1, 1'b0, 1'b0, -100);
        beat(2, 1'b0, 1'b1, 100);
        beat(3, 1'b0, 1'b0, -100);
        run_sched(4, 6);
        for (int k = 0; k <= 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                ev = (k == c + 3) || (k == c + 4);
                ed = (k == c + 3) ? 200 : -200;
                n_checks++;
                if (cap_v[k][c] !== ev) $display("FAIL sat_wide_valid k=%0d c=%0d got %b exp %b", k, c, cap_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (cap_d[k][c] !== 32'(ed)) $display("FAIL sat_wide_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(cap_d[k][c]), ed);
                    else n_pass++;
                end
            end
            for (int c = 0; c < 2; c++) begin
                ev = (k == c + 3) || (k == c + 4);
                es = (k == c + 3) ? 127 : -128;
                ew = (k == c + 3) ? -56 : 56;
                n_checks++;
                if (sv_v[k][c] !== ev || wv_v[k][c] !== ev)
                    $display("FAIL sat8_valid k=%0d c=%0d got %b/%b exp %b", k, c, sv_v[k][c], wv_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (sv_d[k][c] !== 8'(es)) $display("FAIL sat8_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(sv_d[k][c]), es);
                    else n_pass++;
                    n_checks++;
                    if (wv_d[k][c] !== 8'(ew)) $display("FAIL wrap8_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(wv_d[k][c]), ew);
                    else n_pass++;
                end
            end
            n_checks++;
            if (sv_dn[k] !== (k == 5)) $display("FAIL sat8_done k=%0d got %b exp %b", k, sv_dn[k], (k == 5));
            else n_pass++;
        end
        n_checks++;
        if (sv_o[3] !== 2'b01 || wv_o[3] !== 2'b01) $display("FAIL ovf_skew got %b/%b exp 01", sv_o[3], wv_o[3]);
        else n_pass++;
        n_checks++;
        if (sv_o[10] !== 2'b11 || wv_o[10] !== 2'b11) $display("FAIL ovf_set got %b/%b exp 11", sv_o[10], wv_o[10]);
        else n_pass++;
        n_checks++;
        if (cap_ovf[10] !== 4'b0) $display("FAIL ovf_wide got %b exp 0000", cap_ovf[10]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ev;
        int   ed;
        clr_sched();
        beat(0, 1'b1, 1'b1, 4);
        beat(1, 1'b0, 1'b0, 6);
        beat(2, 1'b1, 1'b1, 1);
        beat(3, 1'b0, 1'b0, 2);
        run_sched(4, 7);
        for (int k = 0; k <= 11; k++) begin
            for (int c = 0; c < 4; c++) begin
                ev = (k >= c + 1) && (k <= c + 4);
                case (k - c)
                    1:       ed = 4;
                    2:       ed = 6;
                    3:       ed = 1;
                    default: ed = 2;
                endcase
                n_checks++;
                if (cap_v[k][c] !== ev) $display("FAIL b2b_valid k=%0d c=%0d got %b exp %b", k, c, cap_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (cap_d[k][c] !== 32'(ed)) $display("FAIL b2b_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(cap_d[k][c]), ed);
                    else n_pass++;
                end
            end
            n_checks++;
            if (cap_done[k] !== (k == 5 || k == 7)) $display("FAIL b2b_done k=%0d got %b exp %b", k, cap_done[k], (k == 5 || k == 7));
            else n_pass++;
        end
        n_checks++;
        if (sv_o[11] !== 2'b00 || wv_o[11] !== 2'b00) $display("FAIL ovf_clear got %b/%b exp 00", sv_o[11], wv_o[11]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic ev;
        int   ed;
        clr_sched();
        beat(0, 1'b1, 1'b0, 7);
        beat(1, 1'b0, 1'b0, 7);
        beat(2, 1'b0, 1'b1, 1);
        beat(3, 1'b0, 1'b0, 1);
        sched_r[4] = 1'b1;
        beat(10, 1'b1, 1'b1, 0);
        beat(11, 1'b0, 1'b0, 0);
        for (int c = 0; c < 4; c++) begin
            sched_d[10][c] = 10 + c;
            sched_d[11][c] = -(20 + c);
        end
        run_sched(12, 7);
        n_checks++;
        if (cap_v[5] !== 4'b0 || cap_d[5] !== '0 || cap_ovf[5] !== 4'b0 || cap_done[5] !== 1'b0)
            $display("FAIL rst_mid_state got v=%b d=%h o=%b exp 0", cap_v[5], cap_d[5], cap_ovf[5]);
        else n_pass++;
        for (int k = 5; k <= 18; k++) begin
            for (int c = 0; c < 4; c++) begin
                ev = (k == c + 11) || (k == c + 12);
                ed = (k == c + 11) ? (10 + c) : -(20 + c);
                n_checks++;
                if (cap_v[k][c] !== ev) $display("FAIL rst_mid_valid k=%0d c=%0d got %b exp %b", k, c, cap_v[k][c], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (cap_d[k][c] !== 32'(ed)) $display("FAIL rst_mid_data k=%0d c=%0d got %0d exp %0d", k, c, $signed(cap_d[k][c]), ed);
                    else n_pass++;
                end
            end
            n_checks++;
            if (cap_done[k] !== (k == 15)) $display("FAIL rst_mid_done k=%0d got %b exp %b", k, cap_done[k], (k == 15));
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; in_data = '0;
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_gaps();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 Parameter COLS, default 4: number of accumulator columns.
REQ-002 Parameter P_BW, default 16: signed input partial-sum width.
REQ-003 Parameter ACC_BW, default 32: signed accumulator width; ACC_BW >= P_BW.
REQ-004 Parameter DEPTH, default 8: accumulator entries per column (rows per pass); DEPTH >= 2.
REQ-005 Parameter SAT, default 1: 1 = saturating add, 0 = two's-complement wrap.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  column-0 beat valid.
REQ-009 in_start  in  1  pass flag: first pass of tile; entries are loaded, not added.
REQ-010 in_last  in  1  pass flag: final pass of tile; results are emitted.
REQ-011 in_data  in  COLS x P_BW  partial sums; column c data is skewed, arriving c cycles after column 0.
REQ-012 out_valid  out  COLS  per-column result strobe.
REQ-013 out_data  out  COLS x ACC_BW  per-column accumulated result.
REQ-014 overflow  out  COLS  sticky per-column overflow/saturation flag.
REQ-015 done  out  1  single-cycle pulse at tile completion.

Function
REQ-016 A pass SHALL be DEPTH valid beats; row pointer advances 0..DEPTH-1 on each in_valid, wrapping to 0 after DEPTH-1.
REQ-017 in_start/in_last SHALL be latched on the beat with row pointer 0; values on other beats SHALL be ignored.
REQ-018 Cycles with in_valid=0 SHALL hold the row pointer and change no entry; gaps of any length are legal mid-pass.
REQ-019 Control (valid, row, start, last) SHALL propagate through a shift chain; column c SHALL act on a beat exactly c cycles after column 0 and SHALL sample in_data[c] in that cycle.
REQ-020 Start pass: entry[row] SHALL be set to sign-extended in_data[c].
REQ-021 Non-start pass: entry[row] SHALL be set to entry[row] + sign-extended in_data[c].
REQ-022 SAT=1: sum SHALL clamp to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1]; SAT=0: sum SHALL wrap modulo 2^ACC_BW.
REQ-023 overflow[c] SHALL set on any signed overflow in column c and clear on a start-pass beat in that column.
REQ-024 Last pass: out_valid[c] SHALL pulse one cycle after column c acts, with out_data[c] equal to the new entry value (REQ-020/021 result).
REQ-025 Start and last in the same pass: out_data[c] SHALL equal sign-extended in_data[c].
REQ-026 Outside result cycles, out_valid[c]=0 and out_data[c] SHALL hold its last value.
REQ-027 done SHALL pulse in the same cycle as out_valid[COLS-1] for row DEPTH-1 of a last pass.
REQ-028 A new pass MAY begin on the beat after row DEPTH-1 with no bubble; the skew chain SHALL keep back-to-back passes independent.
REQ-029 There is no backpressure; the consumer SHALL accept every out_valid pulse.

Reset
REQ-030 On rst: row pointer, skew chain, latched pass flags, out_valid, out_data, overflow and done SHALL all be 0.
REQ-031 Entry contents MAY be left uncleared; the first pass after reset SHALL be a start pass.
REQ-032 Reset mid-pass SHALL discard in-flight beats; no out_valid or done SHALL be produced for them.

Verification
REQ-033 COLS=4, DEPTH=2, single start+last pass, row data 5 and -3 in every column, beats at cycles 0-1 -> out_valid[c] at cycles c+1 and c+2 with values 5 and -3; done at cycle 5.
REQ-034 Three passes (start, middle, last), each beat data 1 -> every result = 3; overflow = 0.
REQ-035 SAT=1, ACC_BW=P_BW=8, two passes of 100 in each row -> result 127, overflow=1; SAT=0 -> result -56, overflow=1.
REQ-036 in_valid gaps of 3 cycles between beats within a pass -> results identical to the gap-free run, each shifted by the gap.
REQ-037 rst asserted after row 1 of a last pass -> no further out_valid or done; the next start+last pass completes correctly.
REQ-038 Back-to-back tiles with no idle cycle -> second tile's start loads without adding the first tile's values; two done pulses DEPTH cycles apart.
